xlr8_pwr_seq: RTL

Power-reduction sequencer for XLR8 peripheral clock enables. Software writes a target gating mask through an I/O or data-memory register. The block then gates or ungates each peripheral one at a time, using a stop request/acknowledge handshake, so that no peripheral loses its clock mid-transaction. It sits beside the clock generator on clk_cpu and drives per-peripheral clock enables into the timer, USART, SPI, TWI and ADC wrappers.

---
 rtl/xlr8_pwr_seq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/xlr8_pwr_seq.sv
// xlr8_pwr_seq - peripheral clock-gating sequencer on clk_cpu.
// Software writes a target gating mask; peripherals are then gated or
// ungated one at a time through a stop_req/stop_ack handshake.
// Optional build macro XLR8_PWRSEQ_TIMEOUT_EN: forces gating after
// ACK_TIMEOUT request cycles without acknowledge and sets a sticky tmo flag.
module xlr8_pwr_seq #(
   parameter logic [7:0] CTRL_ADDR   = 8'h00,
   parameter logic [7:0] STAT_ADDR   = 8'h01,
   parameter int         NUM_PERIPH  = 6,
   parameter int         ACK_TIMEOUT = 255,
   parameter int         WAKE_CYCLES = 4
) (
   input  logic                  clk_cpu,
   input  logic                  core_rstn,
   input  logic [5:0]            adr,
   input  logic [7:0]            dbus_in,
   output logic [7:0]            dbus_out,
   input  logic                  iore,
   input  logic                  iowe,
   output logic                  io_out_en,
   input  logic [7:0]            ramadr,
   input  logic                  ramre,
   input  logic                  ramwe,
   input  logic                  dm_sel,
   output logic [NUM_PERIPH-1:0] stop_req,
   input  logic [NUM_PERIPH-1:0] stop_ack,
   output logic [NUM_PERIPH-1:0] clk_en,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GATE = 2'd2,
      ST_WAKE = 2'd3
   } state_t;

   localparam logic [2:0] LAST_IDX  = 3'(NUM_PERIPH - 1);
   localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);
`ifdef XLR8_PWRSEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);
`endif

   // Addresses at or above 8'h60 live in data memory space, below in I/O space.
   function automatic logic reg_hit(input logic [7:0] addr, input logic [5:0] io_a,
                                    input logic [7:0] ram_a, input logic io_strb,
                                    input logic ram_strb, input logic sel);
      logic hit;
      if (addr >= 8'h60) hit = sel & ram_strb & (ram_a == addr);
      else               hit = io_strb & (io_a == addr[5:0]);
      return hit;
   endfunction

   // Lowest mismatched index at or above start, wrapping; result is {found, idx}.
   function automatic logic [3:0] pick_next(input logic [NUM_PERIPH-1:0] diff,
                                            input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] k3;
      int         k;
      res = 4'h0;
      for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
         k = int'(start) + i;
         if (k >= NUM_PERIPH) k = k - NUM_PERIPH;
         else                 k = k;
         k3 = 3'(k);
         if (diff[k3]) res = {1'b1, k3};
         else          res = res;
      end
      return res;
   endfunction

   state_t                  state_r, state_nx_s;
   logic [2:0]              idx_r, idx_nx_s, ptr_r, ptr_nx_s;
   logic [NUM_PERIPH-1:0]   target_r, gated_r, gated_nx_s;
   logic [NUM_PERIPH-1:0]   stop_req_r, stop_req_nx_s, clk_en_r, clk_en_nx_s;
   logic [3:0]              wcnt_r, wcnt_nx_s;
   logic [3:0]              pick_s;
   logic                    ctrl_wr_s, ctrl_rd_s, stat_wr_s, stat_rd_s, tmo_s;
   logic [7:0]              ctrl_img_s, stat_img_s;
   logic                    unused_s;
`ifdef XLR8_PWRSEQ_TIMEOUT_EN
   logic [7:0]              tcnt_r, tcnt_nx_s;
   logic                    tmo_r, tmo_set_s;
`endif

   assign ctrl_wr_s = reg_hit(CTRL_ADDR, adr, ramadr, iowe, ramwe, dm_sel);
   assign ctrl_rd_s = reg_hit(CTRL_ADDR, adr, ramadr, iore, ramre, dm_sel);
   assign stat_wr_s = reg_hit(STAT_ADDR, adr, ramadr, iowe, ramwe, dm_sel);
   assign stat_rd_s = reg_hit(STAT_ADDR, adr, ramadr, iore, ramre, dm_sel);
   assign pick_s    = pick_next(target_r ^ gated_r, ptr_r);
   assign unused_s  = ^{dbus_in[7:NUM_PERIPH], stat_wr_s, (ACK_TIMEOUT > 0)};

   // Target mask register: a software write is accepted in every FSM state
   always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn)     target_r <= {NUM_PERIPH{1'b0}};
      else if (ctrl_wr_s) target_r <= dbus_in[NUM_PERIPH-1:0];
      else                target_r <= target_r;
   end

`ifdef XLR8_PWRSEQ_TIMEOUT_EN
   // Sticky timeout flag: set by a forced gate, cleared by writing 1 to bit 6
   always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn)                   tmo_r <= 1'b0;
      else if (tmo_set_s)               tmo_r <= 1'b1;
      else if (stat_wr_s && dbus_in[6]) tmo_r <= 1'b0;
      else                              tmo_r <= tmo_r;
   end

   // Request-state acknowledge timeout counter
   always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn) tcnt_r <= 8'd0;
      else            tcnt_r <= tcnt_nx_s;
   end
   assign tmo_s = tmo_r;
`else
   assign tmo_s = 1'b0;
`endif

   // FSM state and per-peripheral enable/request/gated registers
   always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn) begin
         state_r    <= ST_IDLE;
         idx_r      <= 3'd0;
         ptr_r      <= 3'd0;
         gated_r    <= {NUM_PERIPH{1'b0}};
         stop_req_r <= {NUM_PERIPH{1'b0}};
         clk_en_r   <= {NUM_PERIPH{1'b1}};
         wcnt_r     <= 4'd0;
      end else begin
         state_r    <= state_nx_s;
         idx_r      <= idx_nx_s;
         ptr_r      <= ptr_nx_s;
         gated_r    <= gated_nx_s;
         stop_req_r <= stop_req_nx_s;
         clk_en_r   <= clk_en_nx_s;
         wcnt_r     <= wcnt_nx_s;
      end
   end

   // Next state: pick one peripheral, handshake it, then gate or wake it
   always_comb begin
      state_nx_s    = state_r;
      idx_nx_s      = idx_r;
      ptr_nx_s      = ptr_r;
      gated_nx_s    = gated_r;
      stop_req_nx_s = stop_req_r;
      clk_en_nx_s   = clk_en_r;
      wcnt_nx_s     = wcnt_r;
`ifdef XLR8_PWRSEQ_TIMEOUT_EN
      tcnt_nx_s     = tcnt_r;
      tmo_set_s     = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (pick_s[3]) begin
               idx_nx_s = pick_s[2:0];
               if (pick_s[2:0] == LAST_IDX) ptr_nx_s = 3'd0;
               else                         ptr_nx_s = pick_s[2:0] + 3'd1;
               if (target_r[pick_s[2:0]]) begin
                  state_nx_s                 = ST_REQ;
                  stop_req_nx_s[pick_s[2:0]] = 1'b1;
`ifdef XLR8_PWRSEQ_TIMEOUT_EN
                  tcnt_nx_s                  = 8'd0;
`endif
               end else begin
                  state_nx_s               = ST_WAKE;
                  clk_en_nx_s[pick_s[2:0]] = 1'b1;
                  wcnt_nx_s                = 4'd0;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            // An abort beats a same-cycle acknowledge
            if (!target_r[idx_r]) begin
               stop_req_nx_s[idx_r] = 1'b0;
               state_nx_s           = ST_IDLE;
            end else if (stop_ack[idx_r]) begin
               state_nx_s = ST_GATE;
`ifdef XLR8_PWRSEQ_TIMEOUT_EN
            end else if (tcnt_r == TMO_LAST) begin
               state_nx_s = ST_GATE;
               tmo_set_s  = 1'b1;
            end else begin
               tcnt_nx_s = tcnt_r + 8'd1;
`else
            end else begin
               state_nx_s = ST_REQ;
`endif
            end
         end
         ST_GATE: begin
            clk_en_nx_s[idx_r] = 1'b0;
            gated_nx_s[idx_r]  = 1'b1;
            state_nx_s         = ST_IDLE;
         end
         ST_WAKE: begin
            if (wcnt_r == WAKE_LAST) begin
               stop_req_nx_s[idx_r] = 1'b0;
               gated_nx_s[idx_r]    = 1'b0;
               state_nx_s           = ST_IDLE;
            end else begin
               wcnt_nx_s = wcnt_r + 4'd1;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Register read-back images; unused bits read 0
   always_comb begin
      ctrl_img_s                   = 8'h00;
      ctrl_img_s[NUM_PERIPH-1:0]   = target_r;
      stat_img_s                   = 8'h00;
      stat_img_s[NUM_PERIPH-1:0]   = gated_r;
      stat_img_s[6]                = tmo_s;
      stat_img_s[7]                = busy;
   end

   // Combinational read data multiplexer
   always_comb begin
      if (ctrl_rd_s)      dbus_out = ctrl_img_s;
      else if (stat_rd_s) dbus_out = stat_img_s;
      else                dbus_out = 8'h00;
   end

   assign io_out_en = ctrl_rd_s | stat_rd_s;
   assign stop_req  = stop_req_r;
   assign clk_en    = clk_en_r;
   assign busy      = (state_r != ST_IDLE);

endmodule
